// File: rtl/ssk_kdf_seq.sv
// Session-key derivation sequencer: runs 2 or 4 PRF rounds per cipher suite and
// writes each 384-bit PRF block into the session key store.
module ssk_kdf_seq #(
  parameter int TMO_W   = 16,
  parameter int TMO_CYC = 4096,
  parameter int DATA_W  = 384
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              abort,
  input  logic              host_wr,
  output logic              prf_req,
  output logic [1:0]        prf_mode,
  output logic [1:0]        prf_idx,
  input  logic              prf_vld,
  input  logic [DATA_W-1:0] prf_d,
  output logic              ssk_wr,
  output logic [3:0]        ssk_addr,
  output logic [DATA_W-1:0] mac,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, REQ, WRITE, DONE} state_t;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

  state_t            r_state;
  logic [1:0]        r_mode;
  logic [1:0]        r_idx;
  logic [TMO_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_mac;
  logic [3:0]        r_addr;
  logic              r_req;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic              w_wr_ok;

  // Suite 0/1 use slots 0-3 / 4-7; AEAD256 uses C,D and AEAD128 uses 8,9.
  function automatic logic [3:0] slot_addr(input logic [1:0] m, input logic [1:0] idx);
    case (m)
      2'd0:    slot_addr = {2'b00, idx};
      2'd1:    slot_addr = {2'b01, idx};
      2'd2:    slot_addr = {3'b110, idx[0]};
      default: slot_addr = {3'b100, idx[0]};
    endcase
  endfunction

  function automatic logic last_round(input logic [1:0] m, input logic [1:0] idx);
    last_round = m[1] ? (idx == 2'd1) : (idx == 2'd3);
  endfunction

  assign w_wr_ok = (r_state == WRITE) && !host_wr && !abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_mode  <= 2'd0;
      r_idx   <= 2'd0;
      r_cnt   <= '0;
      r_mac   <= '0;
      r_addr  <= 4'd0;
      r_req   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (abort) begin
        // Abort beats start, prf_vld and any pending write.
        r_state <= IDLE;
        r_req   <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (start) begin
              r_state <= REQ;
              r_mode  <= mode;
              r_idx   <= 2'd0;
              r_cnt   <= '0;
              r_req   <= 1'b1;
              r_busy  <= 1'b1;
            end
          end
          REQ: begin
            if (prf_vld) begin
              r_mac   <= prf_d;
              r_req   <= 1'b0;
              r_addr  <= slot_addr(r_mode, r_idx);
              r_state <= WRITE;
            end else if (r_cnt == TMO_LAST) begin
              r_err   <= 1'b1;
              r_req   <= 1'b0;
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end else begin
              r_cnt <= r_cnt + TMO_W'(1);
            end
          end
          WRITE: begin
            if (!host_wr) begin
              if (last_round(r_mode, r_idx)) begin
                r_done  <= 1'b1;
                r_state <= DONE;
              end else begin
                r_idx   <= r_idx + 2'd1;
                r_cnt   <= '0;
                r_req   <= 1'b1;
                r_state <= REQ;
              end
            end
          end
          DONE: begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign prf_req  = r_req;
  assign prf_mode = r_mode;
  assign prf_idx  = r_idx;
  assign ssk_wr   = w_wr_ok;
  assign ssk_addr = r_addr;
  assign mac      = r_mac;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;

endmodule

// File: tb/tb_ssk_kdf_seq.sv
// Directed bench for ssk_kdf_seq: table of full derivation runs plus hand-written
// timeout, abort and reset sequences.
module tb_ssk_kdf_seq;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   mode_in = 2'd0;
  logic         abort = 1'b0;
  logic         host_wr = 1'b0;
  logic         prf_req;
  logic [1:0]   prf_mode;
  logic [1:0]   prf_idx;
  logic         prf_vld = 1'b0;
  logic [383:0] prf_d = '0;
  logic         ssk_wr;
  logic [3:0]   ssk_addr;
  logic [383:0] mac;
  logic         busy;
  logic         done;
  logic         err;

  ssk_kdf_seq dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode_in), .abort(abort),
    .host_wr(host_wr), .prf_req(prf_req), .prf_mode(prf_mode), .prf_idx(prf_idx),
    .prf_vld(prf_vld), .prf_d(prf_d), .ssk_wr(ssk_wr), .ssk_addr(ssk_addr),
    .mac(mac), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_wr = 0;
  int n_done = 0;
  int n_err = 0;

  always @(negedge clk) begin
    if (ssk_wr === 1'b1) n_wr <= n_wr + 1;
    if (done === 1'b1)   n_done <= n_done + 1;
    if (err === 1'b1)    n_err <= n_err + 1;
  end

  typedef struct {
    logic [1:0]      mode;
    int              nrnd;
    logic [3:0][3:0] addrs;
    int              lat;
    int              stall;
    bit              poke;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string nm, input logic [383:0] act, input logic [383:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [383:0] blk(input logic [1:0] m, input int r);
    logic [31:0] w;
    w = 32'hC0DE0000 + 32'(m) * 32'd256 + 32'(r);
    return {12{w}};
  endfunction

  task automatic run_vec(input int i);
    vec_t v;
    int w0, d0, k;
    logic [383:0] b;
    v  = vecs[i];
    w0 = n_wr;
    d0 = n_done;
    chk("idle_busy", busy, 0);
    mode_in = v.mode;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("req_rise", prf_req, 1);
    chk("busy_rise", busy, 1);
    chk("mode_latch", prf_mode, v.mode);
    for (int r = 0; r < v.nrnd; r++) begin
      k = 0;
      while (!prf_req && k < 20) begin step(); k++; end
      chk("req_wait", prf_req, 1);
      chk("prf_idx", prf_idx, r);
      for (int l = 0; l < v.lat; l++) begin
        if (v.poke && r == 1 && l == 0) begin
          mode_in = ~v.mode;
          start = 1'b1;
        end
        step();
        start = 1'b0;
        mode_in = v.mode;
      end
      chk("req_held", prf_req, 1);
      b = blk(v.mode, r);
      prf_vld = 1'b1;
      prf_d = b;
      step();
      prf_vld = 1'b0;
      prf_d = '0;
      chk("req_fall", prf_req, 0);
      chk("ssk_addr", ssk_addr, v.addrs[r]);
      chk("mac", mac, b);
      chk("mode_hold", prf_mode, v.mode);
      host_wr = (v.stall > 0);
      for (int s = 0; s < v.stall; s++) begin
        prf_vld = (s == 0);
        prf_d = ~b;
        #1;
        chk("stall_nowr", ssk_wr, 0);
        step();
        prf_vld = 1'b0;
        prf_d = '0;
      end
      host_wr = 1'b0;
      #1;
      chk("wr_pulse", ssk_wr, 1);
      chk("mac_at_wr", mac, b);
      step();
      chk("wr_single", ssk_wr, 0);
    end
    chk("done_pulse", done, 1);
    chk("busy_in_done", busy, 1);
    step();
    chk("done_clear", done, 0);
    chk("busy_fall", busy, 0);
    chk("wr_count", n_wr - w0, v.nrnd);
    chk("done_count", n_done - d0, 1);
  endtask

  initial begin
    int k, w0, d0, e0;
    vecs[0] = '{mode: 2'd1, nrnd: 4, addrs: {4'h7, 4'h6, 4'h5, 4'h4}, lat: 5, stall: 0, poke: 1'b0};
    vecs[1] = '{mode: 2'd2, nrnd: 2, addrs: {4'h0, 4'h0, 4'hD, 4'hC}, lat: 2, stall: 3, poke: 1'b0};
    vecs[2] = '{mode: 2'd0, nrnd: 4, addrs: {4'h3, 4'h2, 4'h1, 4'h0}, lat: 0, stall: 1, poke: 1'b0};
    vecs[3] = '{mode: 2'd3, nrnd: 2, addrs: {4'h0, 4'h0, 4'h9, 4'h8}, lat: 2, stall: 0, poke: 1'b1};

    #12;
    chk("rst_req", prf_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", ssk_addr, 0);
    chk("rst_mac", mac, 0);
    chk("rst_wr", ssk_wr, 0);
    chk("rst_flags", {done, err, prf_idx, prf_mode}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    step();

    for (int i = 0; i < 4; i++) run_vec(i);

    // PRF never answers: err after exactly TMO_CYC cycles from request rise.
    w0 = n_wr;
    e0 = n_err;
    mode_in = 2'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    k = 0;
    while (!err && k < 5000) begin step(); k++; end
    chk("tmo_cycles", k, 4096);
    chk("tmo_req_low", prf_req, 0);
    chk("tmo_busy_low", busy, 0);
    chk("tmo_no_wr", n_wr - w0, 0);
    step();
    chk("tmo_err_single", err, 0);
    chk("tmo_err_count", n_err - e0, 1);

    // Abort colliding with prf_vld of round 0.
    w0 = n_wr; d0 = n_done; e0 = n_err;
    mode_in = 2'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    prf_vld = 1'b1;
    prf_d = {12{32'hDEADBEEF}};
    abort = 1'b1;
    step();
    prf_vld = 1'b0;
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_req", prf_req, 0);
    chk("abort_mac_kept", mac, blk(2'd3, 1));
    step();
    step();
    chk("abort_no_wr", n_wr - w0, 0);
    chk("abort_no_done_err", (n_done - d0) + (n_err - e0), 0);

    // Abort while a write is pending forces ssk_wr low.
    w0 = n_wr;
    mode_in = 2'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    prf_vld = 1'b1;
    prf_d = blk(2'd1, 3);
    step();
    prf_vld = 1'b0;
    abort = 1'b1;
    #1;
    chk("abort_wr_forced", ssk_wr, 0);
    step();
    abort = 1'b0;
    chk("abort_wr_busy", busy, 0);
    step();
    chk("abort_wr_none", n_wr - w0, 0);

    // Reset in WRITE during a host stall, then a fresh run from round 0.
    mode_in = 2'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    prf_vld = 1'b1;
    prf_d = blk(2'd2, 0);
    step();
    prf_vld = 1'b0;
    host_wr = 1'b1;
    step();
    rst = 1'b1;
    #1;
    chk("arst_outs", {prf_req, busy, done, err, ssk_wr, ssk_addr, prf_idx, prf_mode}, 0);
    chk("arst_mac", mac, 0);
    step();
    rst = 1'b0;
    host_wr = 1'b0;
    step();
    chk("post_rst_idle", busy, 0);
    run_vec(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
